// File: rtl/darklsu.sv
// darklsu: load/store stage of the multicycle datapath.
// On an accepted en the instruction, address and store data are captured.
// One cycle later the captured operation is decoded. A passthrough or a
// faulting op finishes at that point. A legal load/store issues one aligned
// word transaction and finishes when the bus completes or the wait budget
// runs out.
module darklsu #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              res,
  input  logic              en,
  output logic              valid,
  input  logic [31:0]       inst,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              bus_en,
  output logic              bus_rw,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_valid
);

  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t state, state_d;

  // Captured operation; pend marks a capture waiting for its decode cycle.
  logic              pend, pend_d;
  logic [6:0]        op_q;
  logic [2:0]        f3_q;
  logic [31:0]       addr_q;
  logic [31:0]       data_q;
  logic              take;

  logic [31:0]       cnt, cnt_d;

  logic              is_mem, is_store, f3_bad, misal, timeout_hit;
  logic [3:0]        be_v;
  logic [31:0]       wdata_v, load_v;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  logic              valid_d, err_d, bus_en_d, bus_rw_d;
  logic [1:0]        err_code_d;
  logic [3:0]        bus_be_d;
  logic [31:0]       data_d, bus_addr_d, bus_wdata_d;

  logic              unused_inst_bits;
  assign unused_inst_bits = ^{inst[31:15], inst[11:7]};

  assign take = (state == S_IDLE) && !pend && en;

  // Decode of the captured operation: legality, alignment, lanes.
  always_comb begin
    is_mem   = (op_q == OP_LOAD) || (op_q == OP_STORE);
    is_store = (op_q == OP_STORE);
    if (is_store)
      f3_bad = f3_q[2] || (f3_q[1:0] == 2'b11);
    else
      f3_bad = (f3_q[1:0] == 2'b11) || (f3_q == 3'b110);
    misal = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
            ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    case (f3_q[1:0])
      2'b00:   be_v = 4'b0001 << addr_q[1:0];
      2'b01:   be_v = 4'b0011 << addr_q[1:0];
      default: be_v = 4'b1111;
    endcase
    wdata_v = '0;
    if (is_store) begin
      case (f3_q[1:0])
        2'b00:   wdata_v = {4{data_q[7:0]}};
        2'b01:   wdata_v = {2{data_q[15:0]}};
        default: wdata_v = data_q;
      endcase
    end
  end

  // Load lane extraction with sign/zero extension.
  always_comb begin
    byte_v = bus_rdata[8*addr_q[1:0] +: 8];
    half_v = bus_rdata[16*addr_q[1] +: 16];
    case (f3_q)
      3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_v = {24'h0, byte_v};
      3'b001:  load_v = {{16{half_v[15]}}, half_v};
      3'b101:  load_v = {16'h0, half_v};
      default: load_v = bus_rdata;
    endcase
  end

  // Bus completion beats the wait budget on the same edge.
  assign timeout_hit = (TIMEOUT != 32'd0) && (cnt == TO_LAST) && !bus_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (res) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (pend) state_d = (is_mem && !f3_bad && !misal) ? S_REQ : S_DONE;
      S_REQ:   if (bus_valid || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the wait counter.
  always_comb begin
    valid_d     = 1'b0;
    err_d       = 1'b0;
    err_code_d  = 2'b00;
    data_d      = data_o;
    bus_en_d    = bus_en;
    bus_rw_d    = bus_rw;
    bus_be_d    = bus_be;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    cnt_d       = cnt;
    pend_d      = pend;
    case (state)
      S_IDLE: begin
        if (pend) begin
          pend_d = 1'b0;
          if (!is_mem) begin
            valid_d = 1'b1;
            data_d  = data_q;
          end else if (f3_bad || misal) begin
            valid_d    = 1'b1;
            err_d      = 1'b1;
            err_code_d = f3_bad ? 2'b11 : 2'b01;
            data_d     = '0;
          end else begin
            bus_en_d    = 1'b1;
            bus_rw_d    = is_store;
            bus_be_d    = be_v;
            bus_addr_d  = {addr_q[31:2], 2'b00};
            bus_wdata_d = wdata_v;
            cnt_d       = '0;
          end
        end else if (en) begin
          pend_d = 1'b1;
        end
      end
      S_REQ: begin
        if (bus_valid) begin
          bus_en_d = 1'b0;
          valid_d  = 1'b1;
          data_d   = bus_rw ? '0 : load_v;
        end else if (timeout_hit) begin
          bus_en_d   = 1'b0;
          valid_d    = 1'b1;
          err_d      = 1'b1;
          err_code_d = 2'b10;
          data_d     = '0;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      default: ;
    endcase
  end

  // Output, counter and capture registers.
  always_ff @(posedge clk) begin
    if (res) begin
      valid     <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      data_o    <= '0;
      bus_en    <= 1'b0;
      bus_rw    <= 1'b0;
      bus_be    <= 4'b0000;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      op_q      <= '0;
      f3_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      valid     <= valid_d;
      err       <= err_d;
      err_code  <= err_code_d;
      data_o    <= data_d;
      bus_en    <= bus_en_d;
      bus_rw    <= bus_rw_d;
      bus_be    <= bus_be_d;
      bus_addr  <= bus_addr_d;
      bus_wdata <= bus_wdata_d;
      cnt       <= cnt_d;
      pend      <= pend_d;
      if (take) begin
        op_q   <= inst[6:0];
        f3_q   <= inst[14:12];
        addr_q <= addr;
        data_q <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_darklsu.sv
// Bench for darklsu: a per-cycle expected timeline built from each
// transaction's description, compared on every falling edge, plus
// hand-computed literal checks.
module tb_darklsu;

  localparam int TIMEOUT_P = 8;
  localparam int MAXC      = 2048;

  localparam logic [31:0] I_LB  = 32'h0000_0003;
  localparam logic [31:0] I_LH  = 32'h0000_1003;
  localparam logic [31:0] I_LW  = 32'h0000_2003;
  localparam logic [31:0] I_L3  = 32'h0000_3003;
  localparam logic [31:0] I_LBU = 32'h0000_4003;
  localparam logic [31:0] I_LHU = 32'h0000_5003;
  localparam logic [31:0] I_SB  = 32'h0000_0023;
  localparam logic [31:0] I_SH  = 32'h0000_1023;
  localparam logic [31:0] I_SW  = 32'h0000_2023;
  localparam logic [31:0] I_S3  = 32'h0000_3023;
  localparam logic [31:0] I_ADD = 32'h00B5_0533;

  logic        clk = 1'b0;
  logic        res, en, valid, err, bus_en, bus_rw, bus_valid;
  logic [31:0] inst, addr, data_i, data_o, bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  err_code;
  logic [3:0]  bus_be;

  darklsu #(.TIMEOUT(TIMEOUT_P), .DATA_W(32)) dut (
    .clk(clk), .res(res), .en(en), .valid(valid), .inst(inst), .addr(addr),
    .data_i(data_i), .data_o(data_o), .err(err), .err_code(err_code),
    .bus_en(bus_en), .bus_rw(bus_rw), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_valid(bus_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  bit        exp_valid[MAXC];
  bit        exp_err[MAXC];
  bit [1:0]  exp_code[MAXC];
  bit [31:0] exp_data[MAXC];
  bit        exp_bus_en[MAXC];
  bit        exp_rw[MAXC];
  bit [3:0]  exp_be[MAXC];
  bit [31:0] exp_addr[MAXC];
  bit [31:0] exp_wdata[MAXC];

  logic        got_valid[MAXC];
  logic        got_bus_en[MAXC];
  logic        got_rw[MAXC];
  logic [1:0]  got_code[MAXC];
  logic [3:0]  got_be[MAXC];
  logic [31:0] got_data[MAXC];
  logic [31:0] got_addr[MAXC];
  logic [31:0] got_wdata[MAXC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, act, expv);
    end
  endtask

  // Expected timeline of one transaction whose en is sampled at edge t.
  // w = wait cycles before bus_valid (negative = never).
  task automatic model_fill(input int t, input logic [31:0] i_inst, input logic [31:0] i_addr,
                            input logic [31:0] i_data, input logic [31:0] i_rdata,
                            input int w, output int vt);
    logic [6:0]  op;
    logic [2:0]  f3;
    int          sz, off, n;
    bit          is_ld, is_st, tmo;
    logic [31:0] mask, v, wd;
    op    = i_inst[6:0];
    f3    = i_inst[14:12];
    is_ld = (op == 7'h03);
    is_st = (op == 7'h23);
    sz    = 1 << f3[1:0];
    off   = int'(i_addr[1:0]);
    vt    = t + 1;
    if (!is_ld && !is_st) begin
      exp_valid[vt] = 1'b1;
      exp_data[vt]  = i_data;
    end else if ((is_ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (is_st && f3 > 2)) begin
      exp_valid[vt] = 1'b1; exp_err[vt] = 1'b1; exp_code[vt] = 2'd3; exp_data[vt] = 0;
    end else if ((sz == 2 && off % 2 != 0) || (sz == 4 && off != 0)) begin
      exp_valid[vt] = 1'b1; exp_err[vt] = 1'b1; exp_code[vt] = 2'd1; exp_data[vt] = 0;
    end else begin
      mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
      tmo  = (w < 0) || (w >= TIMEOUT_P);
      n    = tmo ? TIMEOUT_P : w + 1;
      if (!is_st)       wd = 0;
      else if (sz == 1) wd = (i_data & 32'hFF) * 32'h0101_0101;
      else if (sz == 2) wd = (i_data & 32'hFFFF) * 32'h0001_0001;
      else              wd = i_data;
      for (int k = 1; k <= n; k++) begin
        exp_bus_en[t+k] = 1'b1;
        exp_rw[t+k]     = is_st;
        exp_addr[t+k]   = i_addr & ~32'd3;
        exp_be[t+k]     = 4'(((1 << sz) - 1) << off);
        exp_wdata[t+k]  = wd;
      end
      vt = t + 1 + n;
      exp_valid[vt] = 1'b1;
      if (tmo) begin
        exp_err[vt] = 1'b1; exp_code[vt] = 2'd2; exp_data[vt] = 0;
      end else if (is_st) begin
        exp_data[vt] = 0;
      end else begin
        v = (i_rdata >> (8 * off)) & mask;
        if (f3 < 4 && sz < 4 && v[8*sz-1]) v = v | ~mask;
        exp_data[vt] = v;
      end
    end
  endtask

  // Reset sampled at edge r cancels everything from that edge on.
  task automatic model_clear(input int r);
    for (int k = r; k < MAXC; k++) begin
      exp_valid[k] = 0; exp_err[k] = 0; exp_code[k] = 0; exp_data[k] = 0;
      exp_bus_en[k] = 0; exp_rw[k] = 0; exp_be[k] = 0; exp_addr[k] = 0; exp_wdata[k] = 0;
    end
  endtask

  // Per-cycle comparison against the timeline.
  always @(negedge clk) begin
    if (checking && cyc < MAXC) begin
      got_valid[cyc]  = valid;
      got_bus_en[cyc] = bus_en;
      got_rw[cyc]     = bus_rw;
      got_code[cyc]   = err_code;
      got_be[cyc]     = bus_be;
      got_data[cyc]   = data_o;
      got_addr[cyc]   = bus_addr;
      got_wdata[cyc]  = bus_wdata;
      chk($sformatf("valid@%0d", cyc), 32'(valid), 32'(exp_valid[cyc]));
      chk($sformatf("err@%0d", cyc), 32'(err), 32'(exp_err[cyc]));
      chk($sformatf("err_code@%0d", cyc), 32'(err_code), 32'(exp_code[cyc]));
      chk($sformatf("bus_en@%0d", cyc), 32'(bus_en), 32'(exp_bus_en[cyc]));
      if (exp_valid[cyc])
        chk($sformatf("data_o@%0d", cyc), data_o, exp_data[cyc]);
      if (exp_bus_en[cyc]) begin
        chk($sformatf("bus_addr@%0d", cyc), bus_addr, exp_addr[cyc]);
        chk($sformatf("bus_be@%0d", cyc), 32'(bus_be), 32'(exp_be[cyc]));
        chk($sformatf("bus_rw@%0d", cyc), 32'(bus_rw), 32'(exp_rw[cyc]));
        chk($sformatf("bus_wdata@%0d", cyc), bus_wdata, exp_wdata[cyc]);
      end
    end
  end

  task automatic run_txn(input logic [31:0] i_inst, input logic [31:0] i_addr,
                         input logic [31:0] i_data, input logic [31:0] i_rdata,
                         input int w, input bit mid_en, input bit mid_res,
                         output int t, output int vt);
    int end_c;
    @(negedge clk);
    en = 1'b1; inst = i_inst; addr = i_addr; data_i = i_data;
    t = cyc + 1;
    model_fill(t, i_inst, i_addr, i_data, i_rdata, w, vt);
    @(negedge clk);
    en = 1'b0; inst = 32'h0000_0013; addr = 32'hFFFF_FFFF; data_i = 32'hA5A5_A5A5;
    if (mid_res) begin
      while (cyc < t + 2) @(negedge clk);
      res = 1'b1;
      model_clear(t + 3);
      @(negedge clk);
      res = 1'b0;
      vt = -1;
    end else begin
      if (mid_en) begin
        while (cyc < t + 2) @(negedge clk);
        en = 1'b1; inst = I_ADD; data_i = 32'h7777_7777;
        @(negedge clk);
        en = 1'b0;
      end
      if (w >= 0) begin
        while (cyc < t + 1 + w) @(negedge clk);
        bus_valid = 1'b1; bus_rdata = i_rdata;
        @(negedge clk);
        bus_valid = 1'b0; bus_rdata = 32'h0BAD_F00D;
      end
    end
    end_c = (vt > 0) ? vt : t + 12;
    while (cyc < end_c + 2) @(negedge clk);
    // stray completion while idle must be ignored
    bus_valid = 1'b1;
    @(negedge clk);
    bus_valid = 1'b0;
  endtask

  int t, vt, n;

  initial begin
    res = 1'b1; en = 1'b0; inst = '0; addr = '0; data_i = '0;
    bus_valid = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_bus_en", 32'(bus_en), 0);
    chk("rst_bus_rw", 32'(bus_rw), 0);
    chk("rst_bus_be", 32'(bus_be), 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    res = 1'b0;
    checking = 1'b1;

    run_txn(I_LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, t, vt);
    chk("lw_latency", 32'(vt - t), 2);
    chk("lw_valid", 32'(got_valid[t+2]), 1);
    chk("lw_data", got_data[t+2], 32'hDEAD_BEEF);
    chk("lw_addr", got_addr[t+1], 32'h100);
    chk("lw_be", 32'(got_be[t+1]), 32'hF);

    run_txn(I_LB, 32'h203, 32'h0, 32'h8012_3456, 1, 0, 0, t, vt);
    chk("lb_be", 32'(got_be[t+1]), 32'h8);
    chk("lb_data", got_data[vt], 32'hFFFF_FF80);

    run_txn(I_LBU, 32'h203, 32'h0, 32'h8012_3456, 0, 0, 0, t, vt);
    chk("lbu_data", got_data[vt], 32'h0000_0080);

    run_txn(I_SH, 32'h42, 32'h1234_ABCD, 32'h0, 3, 1, 0, t, vt);
    n = 0;
    for (int k = t; k <= t + 6; k++) if (got_bus_en[k] === 1'b1) n++;
    chk("sh_bus_cycles", 32'(n), 4);
    chk("sh_addr", got_addr[t+4], 32'h40);
    chk("sh_be", 32'(got_be[t+4]), 32'hC);
    chk("sh_wdata", got_wdata[t+1], 32'hABCD_ABCD);
    chk("sh_rw", 32'(got_rw[t+1]), 1);
    chk("sh_valid", 32'(got_valid[t+5]), 1);
    chk("sh_data", got_data[t+5], 0);

    run_txn(I_LH, 32'h101, 32'h0, 32'h0, 0, 0, 0, t, vt);
    chk("lh_mis_valid", 32'(got_valid[t+1]), 1);
    chk("lh_mis_code", 32'(got_code[t+1]), 1);

    run_txn(I_L3, 32'h100, 32'h0, 32'h0, 0, 0, 0, t, vt);
    chk("ld_f3_code", 32'(got_code[t+1]), 3);

    run_txn(I_S3, 32'h101, 32'h0, 32'h0, 0, 0, 0, t, vt);
    chk("st_f3_prio_code", 32'(got_code[t+1]), 3);

    run_txn(I_SW, 32'h102, 32'h1, 32'h0, 0, 0, 0, t, vt);
    run_txn(I_SW, 32'h300, 32'hCAFE_0001, 32'h0, -1, 0, 0, t, vt);
    n = 0;
    for (int k = t; k <= t + 12; k++) if (got_bus_en[k] === 1'b1) n++;
    chk("to_bus_cycles", 32'(n), 8);
    chk("to_code", 32'(got_code[t+9]), 2);
    chk("to_data", got_data[t+9], 0);

    run_txn(I_SW, 32'h304, 32'h1357_9BDF, 32'h0, 0, 0, 0, t, vt);
    run_txn(I_SW, 32'h308, 32'h2468_ACE0, 32'h0, 7, 0, 0, t, vt);
    chk("edge_to_code", 32'(got_code[t+9]), 0);
    run_txn(I_LHU, 32'h102, 32'h0, 32'h8765_4321, 2, 0, 0, t, vt);
    chk("lhu_data", got_data[vt], 32'h0000_8765);
    run_txn(I_LH, 32'h102, 32'h0, 32'h8765_4321, 0, 0, 0, t, vt);
    chk("lh_data", got_data[vt], 32'hFFFF_8765);
    run_txn(I_SB, 32'h1, 32'hAB, 32'h0, 1, 0, 0, t, vt);
    chk("sb_wdata", got_wdata[t+1], 32'hABAB_ABAB);
    chk("sb_be", 32'(got_be[t+1]), 32'h2);

    run_txn(I_ADD, 32'h0, 32'h55, 32'h0, 0, 0, 0, t, vt);
    chk("add_data", got_data[t+1], 32'h55);

    run_txn(I_LW, 32'h400, 32'h0, 32'h0, -1, 0, 1, t, vt);
    n = 0;
    for (int k = t; k <= t + 12; k++) if (got_valid[k] === 1'b1) n++;
    chk("rst_req_no_valid", 32'(n), 0);
    chk("rst_req_bus_en", 32'(got_bus_en[t+3]), 0);

    run_txn(I_LW, 32'h500, 32'h0, 32'h0123_4567, 1, 0, 0, t, vt);
    chk("post_rst_data", got_data[t+3], 32'h0123_4567);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
